// File: rtl/cnt_rr_scheduler.sv
// Round-robin owner of a shared valid-event counter: each granted requester gets
// one window that ends on MAX_COUNT valids or after TIMEOUT cycles.
module cnt_rr_scheduler #(
    parameter int NB_CNT    = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_COUNT = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_valid,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy,
    output logic [NB_CNT-1:0]        o_count,
    output logic                     o_done,
    output logic [$clog2(N_REQ)-1:0] o_done_id,
    output logic                     o_timeout
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [NB_CNT-1:0]  CNT_LAST   = NB_CNT'(MAX_COUNT - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]    ID_LAST    = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   GRANT_LSB  = {{(N_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r, next_state_s;
    logic [TIMER_W-1:0]   timer_r, timer_s;
    logic [ID_W-1:0]      owner_r, owner_s;
    logic [ID_W-1:0]      last_id_r, last_id_s;
    logic [ID_W-1:0]      pick_id_s, idx_s;
    logic                 pick_found_s;
    logic                 valid_own_s, complete_s, window_timeout_s;
    logic [N_REQ-1:0]     grant_s;
    logic                 busy_s, done_s, timeout_flag_s;
    logic [NB_CNT-1:0]    count_s;
    logic [ID_W-1:0]      done_id_s;

    // Round-robin search starting just after the last finished owner
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        idx_s        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = ID_W'((int'(last_id_r) + i) % N_REQ);
            if (!pick_found_s && i_req[idx_s]) begin
                pick_found_s = 1'b1;
                pick_id_s    = idx_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    assign valid_own_s      = i_valid[owner_r];
    assign complete_s       = valid_own_s && (o_count == CNT_LAST);
    assign window_timeout_s = (timer_r == TIMER_LAST) && !complete_s;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    next_state_s = ST_GRANT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (complete_s || window_timeout_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_GRANT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and window bookkeeping
    always_comb begin
        grant_s        = o_grant;
        busy_s         = o_busy;
        count_s        = o_count;
        done_s         = 1'b0;
        done_id_s      = o_done_id;
        timeout_flag_s = 1'b0;
        timer_s        = timer_r;
        owner_s        = owner_r;
        last_id_s      = last_id_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_s = GRANT_LSB << pick_id_s;
                    busy_s  = 1'b1;
                    count_s = '0;
                    timer_s = '0;
                    owner_s = pick_id_s;
                end else begin
                    grant_s = o_grant;
                end
            end
            ST_GRANT: begin
                timer_s = timer_r + TIMER_W'(1);
                count_s = o_count + NB_CNT'(valid_own_s);
                if (complete_s || window_timeout_s) begin
                    grant_s        = '0;
                    done_s         = 1'b1;
                    done_id_s      = owner_r;
                    timeout_flag_s = window_timeout_s;
                    last_id_s      = owner_r;
                end else begin
                    grant_s = o_grant;
                end
            end
            ST_DONE: begin
                busy_s = 1'b0;
            end
            default: begin
                grant_s = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_count   <= '0;
            o_done    <= 1'b0;
            o_done_id <= '0;
            o_timeout <= 1'b0;
            timer_r   <= '0;
            owner_r   <= '0;
            last_id_r <= ID_LAST;
        end else begin
            o_grant   <= grant_s;
            o_busy    <= busy_s;
            o_count   <= count_s;
            o_done    <= done_s;
            o_done_id <= done_id_s;
            o_timeout <= timeout_flag_s;
            timer_r   <= timer_s;
            owner_r   <= owner_s;
            last_id_r <= last_id_s;
        end
    end

endmodule

// File: tb/tb_cnt_rr_scheduler.sv
// Directed bench for cnt_rr_scheduler: stimulus pushes expected grants and window
// reports into queues, a negedge monitor pops and compares them.
module tb_cnt_rr_scheduler;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic [3:0] i_req   = 4'b0000;
    logic [3:0] i_valid = 4'b0000;
    logic [3:0] o_grant;
    logic       o_busy;
    logic [7:0] o_count;
    logic       o_done;
    logic [1:0] o_done_id;
    logic       o_timeout;

    typedef struct {
        logic [1:0] id;
        logic [7:0] cnt;
        logic       to;
        int         len;
    } done_t;

    done_t      exp_done_q[$];
    logic [3:0] exp_grant_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         grant_cyc = 0;
    logic [3:0] prev_grant = 4'b0000;

    cnt_rr_scheduler #(.NB_CNT(8), .N_REQ(4), .MAX_COUNT(8), .TIMEOUT(32)) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_req     (i_req),
        .i_valid   (i_valid),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_count   (o_count),
        .o_done    (o_done),
        .o_done_id (o_done_id),
        .o_timeout (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected grants on grant rise and window reports on o_done
    always @(negedge i_clock) begin
        done_t d;
        if (!i_reset) begin
            if (o_grant != 4'b0000 && prev_grant == 4'b0000) begin
                grant_cyc = cyc;
                if (exp_grant_q.size() == 0) begin
                    check("grant_unexpected", {28'd0, o_grant}, 32'd0);
                end else begin
                    check("grant_value", {28'd0, o_grant}, {28'd0, exp_grant_q.pop_front()});
                end
            end
            if (o_done) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", {31'd0, o_done}, 32'd0);
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_id", {30'd0, o_done_id}, {30'd0, d.id});
                    check("done_count", {24'd0, o_count}, {24'd0, d.cnt});
                    check("done_timeout", {31'd0, o_timeout}, {31'd0, d.to});
                    check("done_len", cyc - grant_cyc, d.len);
                    check("done_grant_low", {28'd0, o_grant}, 32'd0);
                end
            end
        end
        prev_grant <= o_grant;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge i_clock);
            k++;
        end while (!o_done && k < budget);
        if (!o_done) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: no o_done within %0d cycles", budget);
        end
    endtask

    function automatic done_t mk(input logic [1:0] id, input logic [7:0] cnt, input logic to, input int len);
        done_t d;
        d.id = id; d.cnt = cnt; d.to = to; d.len = len;
        return d;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        i_reset = 1'b1;
        idle(3);
        check("rst_grant", {28'd0, o_grant}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_count", {24'd0, o_count}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_done_id", {30'd0, o_done_id}, 32'd0);
        check("rst_timeout", {31'd0, o_timeout}, 32'd0);
        i_reset = 1'b0;
        idle(2);

        // Single requester completes after 8 valids
        exp_grant_q.push_back(4'b0001);
        exp_done_q.push_back(mk(2'd0, 8'd8, 1'b0, 8));
        i_req = 4'b0001; i_valid = 4'b0001;
        @(negedge i_clock);
        check("t1_latency", {28'd0, o_grant}, 32'h1);
        check("t1_busy", {31'd0, o_busy}, 32'd1);
        check("t1_count_clear", {24'd0, o_count}, 32'd0);
        i_req = 4'b0000;
        wait_done(20);
        i_valid = 4'b0000;
        idle(2);
        check("t1_count_hold", {24'd0, o_count}, 32'd8);
        check("t1_idle_busy", {31'd0, o_busy}, 32'd0);

        // Fresh reset, all requesting: full rotation 0,1,2,3,0
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        idle(1);
        exp_grant_q.push_back(4'b0001); exp_done_q.push_back(mk(2'd0, 8'd8, 1'b0, 8));
        exp_grant_q.push_back(4'b0010); exp_done_q.push_back(mk(2'd1, 8'd8, 1'b0, 8));
        exp_grant_q.push_back(4'b0100); exp_done_q.push_back(mk(2'd2, 8'd8, 1'b0, 8));
        exp_grant_q.push_back(4'b1000); exp_done_q.push_back(mk(2'd3, 8'd8, 1'b0, 8));
        exp_grant_q.push_back(4'b0001); exp_done_q.push_back(mk(2'd0, 8'd8, 1'b0, 8));
        i_req = 4'b1111; i_valid = 4'b1111;
        for (int w = 0; w < 5; w++) wait_done(20);
        i_req = 4'b0000; i_valid = 4'b0000;
        idle(2);

        // Ch2 with no valids times out after 32 cycles
        exp_grant_q.push_back(4'b0100);
        exp_done_q.push_back(mk(2'd2, 8'd0, 1'b1, 32));
        i_req = 4'b0100;
        @(negedge i_clock);
        check("t3_latency", {28'd0, o_grant}, 32'h4);
        i_req = 4'b0000;
        wait_done(40);
        idle(2);

        // Ch3: 7 valids, then the 8th on the last timer cycle, completion wins
        exp_grant_q.push_back(4'b1000);
        exp_done_q.push_back(mk(2'd3, 8'd8, 1'b0, 32));
        i_req = 4'b1000;
        @(negedge i_clock);
        check("t4_latency", {28'd0, o_grant}, 32'h8);
        i_req = 4'b0000;
        for (int k = 1; k <= 32; k++) begin
            i_valid = (k <= 7 || k == 32) ? 4'b1000 : 4'b0000;
            @(negedge i_clock);
            if (k == 31) check("t4_count_before", {24'd0, o_count}, 32'd7);
        end
        i_valid = 4'b0000;
        idle(2);

        // Ch1 owner, only non-owner valids, request dropped: timeout with count 0
        exp_grant_q.push_back(4'b0010);
        exp_done_q.push_back(mk(2'd1, 8'd0, 1'b1, 32));
        i_req = 4'b0010;
        @(negedge i_clock);
        check("t5_latency", {28'd0, o_grant}, 32'h2);
        i_req = 4'b0000;
        for (int k = 1; k <= 32; k++) begin
            i_valid = (k % 2 == 1) ? 4'b1001 : 4'b0000;
            @(negedge i_clock);
            if (k == 31) check("t5_hold", {28'd0, o_grant}, 32'h2);
        end
        i_valid = 4'b0000;
        idle(2);

        // Reset mid-window at count 5, then arbitration restarts at requester 0
        exp_grant_q.push_back(4'b0001);
        i_req = 4'b0001; i_valid = 4'b0001;
        @(negedge i_clock);
        check("t6_latency", {28'd0, o_grant}, 32'h1);
        i_req = 4'b0000;
        idle(5);
        check("t6_count5", {24'd0, o_count}, 32'd5);
        i_reset = 1'b1;
        @(negedge i_clock);
        check("t6_rst_grant", {28'd0, o_grant}, 32'd0);
        check("t6_rst_count", {24'd0, o_count}, 32'd0);
        check("t6_rst_done", {31'd0, o_done}, 32'd0);
        check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
        i_reset = 1'b0; i_valid = 4'b0000;
        idle(1);
        exp_grant_q.push_back(4'b0001);
        exp_done_q.push_back(mk(2'd0, 8'd8, 1'b0, 8));
        i_req = 4'b1011; i_valid = 4'b0001;
        @(negedge i_clock);
        check("t6_restart", {28'd0, o_grant}, 32'h1);
        i_req = 4'b0000;
        wait_done(20);
        i_valid = 4'b0000;
        idle(3);

        check("pending_grants", exp_grant_q.size(), 32'd0);
        check("pending_dones", exp_done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
